fft_mag2_peak: RTL
==================

# fft_mag2_peak

Streaming magnitude-squared and peak-bin detector placed directly after the FFT output stage, ahead of the tuner's pitch-estimation logic. Accepts one complex bin `{Re, Im}` per valid cycle and computes Re² + Im² in a 3-stage pipeline. Tracks the largest magnitude within a configurable bin search window. Emits a one-cycle `peak_valid` pulse with the winning bin index and magnitude at the end of every frame.

## Interface
Parameters:
- `bit_width`, 16, signed width of each of Re and Im.
- `n_bins`, 256, bins per frame; must be a power of 2, ≥ 4.
- `min_bin`, 1, lowest bin index searched for the peak; excludes DC by default.
- `max_bin`, 127, highest bin index searched; requires `min_bin ≤ max_bin < n_bins`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  `in_data` carries a bin this cycle.
- `in_data`  in  2·bit_width  `{Re, Im}`, each two's-complement.
- `in_last`  in  1  marks the final bin of a frame; qualified by `in_valid`.
- `mag_valid`  out  1  `mag_data`/`mag_idx` valid.
- `mag_data`  out  2·bit_width  Re² + Im², unsigned.
- `mag_idx`  out  log2(n_bins)  bin index of `mag_data`.
- `peak_valid`  out  1  one-cycle pulse: frame complete.
- `peak_idx`  out  log2(n_bins)  index of the frame's maximum bin.
- `peak_mag`  out  2·bit_width  magnitude at `peak_idx`.
- `frame_err`  out  1  one-cycle pulse: `in_last` misaligned with the bin count.

## Operation
- **Bin counter:** increments on each `in_valid`. It wraps from `n_bins-1` to 0, and that bin is the end of the frame.
- **Arithmetic:** Re² and Im² are computed as signed products and treated as unsigned. The sum needs at most 2·bit_width bits: the maximum is 2^(2·bit_width−1) at Re = Im = −2^(bit_width−1). No truncation loss occurs, and the output is exact.
- **Stage 1:** registers Re, Im, the index, and an end-of-frame flag.
- **Stage 2:** registers both squares.
- **Stage 3:** registers the sum as `mag_data`.
- **Valid handling:** the valid bit travels with the data. Bubbles (`in_valid` = 0) propagate and are never compressed.
- **Peak tracker:** updates on a stage-3 output with `min_bin ≤ idx ≤ max_bin` and `mag > best_mag`. The comparison is strictly greater, so on ties the lowest index wins.
- **Tracker initial value:** `best_idx = min_bin`, `best_mag = 0`. A frame of all zeros therefore reports `min_bin`, 0.
- **End of frame:**
  - The frame ends when the end-of-frame output leaves stage 3.
  - On the next cycle, `peak_valid` = 1 and `peak_idx`/`peak_mag` present the final result, including that last bin.
  - The tracker is re-initialised in the same cycle.
  - `peak_idx`/`peak_mag` hold until the next frame completes.
- **Back-to-back frames:** bin 0 of the next frame may arrive on the cycle after the last bin, with no dead cycles.
- **Reset:**
  - Clears every pipeline valid, the counter and the tracker.
  - Sets all outputs to 0.
  - A reset mid-frame discards the partial frame; no `peak_valid` is produced for it.
- **Frame check:** see Configuration.

## Timing
- Latency from `in_valid` to `mag_valid` is 3 cycles. `mag_idx` is aligned with `mag_data`.
- Latency from the last bin's `in_valid` to `peak_valid` is 4 cycles.
- Throughput is 1 bin/cycle. There is no backpressure and no ready signal; the consumer must accept every output.
- `peak_valid` and `frame_err` are single-cycle pulses.
- `frame_err` is raised 1 cycle after the offending input.

## Configuration
- **`FFT_MAG2_FRAME_CHECK_EN` defined:**
  - `in_last` is checked against the counter.
  - If `in_last` = 1 at count ≠ `n_bins-1` (early), `frame_err` pulses and the counter restarts at 0 on the next bin. The pipelined bins of the aborted frame still emit `mag_valid`, but the tracker is reset and no `peak_valid` is produced.
  - If `in_last` = 0 at count = `n_bins-1` (late or missing), `frame_err` pulses and the frame is still closed normally by the counter.
- **Undefined:** `in_last` is ignored, `frame_err` is tied to 0, and frames are defined solely by the counter.

## Structure
- **Package `fft_mag2_pkg`:**
  - `idx_t` typedef, width log2(n_bins).
  - mag typedef helper, width 2·bit_width.
  - Reset constants for the tracker.
- **Sub-module `fft_mag2_pipe`:** the 3-stage square-and-sum pipeline. It carries valid, index and end-of-frame sideband through the stages.
- **Top level:** the counter, frame check and peak tracker.

## Test plan
Unless noted, `bit_width` = 16 and `n_bins` = 8, with `min_bin` = 1 and `max_bin` = 3.
- Single bin `{Re=3, Im=−4}` → `mag_data` = 25 exactly 3 cycles later, with `mag_idx` = 0.
- Bin `{−32768, −32768}` → `mag_data` = 0x8000_0000, with no wrap.
- Frame of magnitudes [900, 10, 50, 50, 0, 0, 999, 0] → `peak_idx` = 2, `peak_mag` = 50. DC and out-of-window bins are ignored, and the tie resolves to the lower index. `peak_valid` fires 4 cycles after bin 7.
- Two back-to-back frames with random bubbles → two `peak_valid` pulses with correct results; `mag_idx` sequence 0..7, 0..7.
- With the macro defined, `in_last` at bin 4 → `frame_err` pulse, no `peak_valid`, and the next bin is counted as idx 0.
- `reset` asserted at bin 5 of a frame → all outputs 0 on the next cycle, no `peak_valid`, and a fresh frame is processed correctly afterwards.

Source files
------------

// File: rtl/fft_mag2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_mag2_pkg
// Brief    : Shared defaults, default-config types and tracker reset values.
// Revision : 1.0
// ============================================================================
package fft_mag2_pkg;

    localparam int c_def_bit_width = 16;
    localparam int c_def_n_bins    = 256;
    localparam int c_def_min_bin   = 1;
    localparam int c_def_max_bin   = 127;

    typedef logic [$clog2(c_def_n_bins)-1:0] idx_t;
    typedef logic [2*c_def_bit_width-1:0]    mag_t;

    // Tracker restarts at magnitude 0 and index min_bin, so an all-zero frame reports (min_bin, 0).
    localparam int c_trk_mag_rst = 0;

endpackage : fft_mag2_pkg
`default_nettype wire

// File: rtl/fft_mag2_peak_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_mag2_peak_if
// Brief    : Bin stream in, magnitude stream and per-frame peak result out.
// Revision : 1.0
// ============================================================================
interface fft_mag2_peak_if
    import fft_mag2_pkg::*;
#(
    parameter int BIT_WIDTH = c_def_bit_width,
    parameter int N_BINS    = c_def_n_bins
);
    localparam int c_idx_w = $clog2(N_BINS);

    logic                   in_valid;
    logic [2*BIT_WIDTH-1:0] in_data;
    logic                   in_last;
    logic                   mag_valid;
    logic [2*BIT_WIDTH-1:0] mag_data;
    logic [c_idx_w-1:0]     mag_idx;
    logic                   peak_valid;
    logic [c_idx_w-1:0]     peak_idx;
    logic [2*BIT_WIDTH-1:0] peak_mag;
    logic                   frame_err;

    modport master (
        output in_valid, in_data, in_last,
        input  mag_valid, mag_data, mag_idx, peak_valid, peak_idx, peak_mag, frame_err
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output mag_valid, mag_data, mag_idx, peak_valid, peak_idx, peak_mag, frame_err
    );

endinterface : fft_mag2_peak_if
`default_nettype wire

// File: rtl/fft_mag2_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fft_mag2_pipe
// Brief    : 3-stage Re^2 + Im^2 pipeline carrying valid/index/frame sideband.
// Revision : 1.0
// ============================================================================
module fft_mag2_pipe
    import fft_mag2_pkg::*;
#(
    parameter int BIT_WIDTH = c_def_bit_width,
    parameter int IDX_W     = $clog2(c_def_n_bins)
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   i_valid,
    input  wire logic [BIT_WIDTH-1:0]   i_re,
    input  wire logic [BIT_WIDTH-1:0]   i_im,
    input  wire logic [IDX_W-1:0]       i_idx,
    input  wire logic                   i_eof,
    input  wire logic                   i_abort,
    output logic                        o_valid,
    output logic [2*BIT_WIDTH-1:0]      o_mag,
    output logic [IDX_W-1:0]            o_idx,
    output logic                        o_eof,
    output logic                        o_abort
);
    localparam int c_mag_w = 2 * BIT_WIDTH;

    logic                 r_s1_valid, r_s1_eof, r_s1_abort;
    logic [BIT_WIDTH-1:0] r_s1_re, r_s1_im;
    logic [IDX_W-1:0]     r_s1_idx;

    logic                 r_s2_valid, r_s2_eof, r_s2_abort;
    logic [c_mag_w-1:0]   r_s2_sq_re, r_s2_sq_im;
    logic [IDX_W-1:0]     r_s2_idx;

    logic                 r_s3_valid, r_s3_eof, r_s3_abort;
    logic [c_mag_w-1:0]   r_s3_mag;
    logic [IDX_W-1:0]     r_s3_idx;

    // Sign-extend to full product width so the truncated product is the exact square.
    logic signed [c_mag_w-1:0] w_re_ext, w_im_ext, w_re_sq, w_im_sq;
    assign w_re_ext = {{BIT_WIDTH{r_s1_re[BIT_WIDTH-1]}}, r_s1_re};
    assign w_im_ext = {{BIT_WIDTH{r_s1_im[BIT_WIDTH-1]}}, r_s1_im};
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_eof   <= 1'b0;
            r_s1_abort <= 1'b0;
            r_s1_re    <= '0;
            r_s1_im    <= '0;
            r_s1_idx   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_eof   <= 1'b0;
            r_s2_abort <= 1'b0;
            r_s2_sq_re <= '0;
            r_s2_sq_im <= '0;
            r_s2_idx   <= '0;
            r_s3_valid <= 1'b0;
            r_s3_eof   <= 1'b0;
            r_s3_abort <= 1'b0;
            r_s3_mag   <= '0;
            r_s3_idx   <= '0;
        end else begin
            r_s1_valid <= i_valid;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
            if (i_valid) begin
                r_s1_re    <= i_re;
                r_s1_im    <= i_im;
                r_s1_idx   <= i_idx;
                r_s1_eof   <= i_eof;
                r_s1_abort <= i_abort;
            end
            if (r_s1_valid) begin
                r_s2_sq_re <= w_re_sq;
                r_s2_sq_im <= w_im_sq;
                r_s2_idx   <= r_s1_idx;
                r_s2_eof   <= r_s1_eof;
                r_s2_abort <= r_s1_abort;
            end
            if (r_s2_valid) begin
                r_s3_mag   <= r_s2_sq_re + r_s2_sq_im;
                r_s3_idx   <= r_s2_idx;
                r_s3_eof   <= r_s2_eof;
                r_s3_abort <= r_s2_abort;
            end
        end
    end

    assign o_valid = r_s3_valid;
    assign o_mag   = r_s3_mag;
    assign o_idx   = r_s3_idx;
    assign o_eof   = r_s3_eof;
    assign o_abort = r_s3_abort;

endmodule : fft_mag2_pipe
`default_nettype wire

// File: rtl/fft_mag2_peak.sv
`default_nettype none
// ============================================================================
// Module   : fft_mag2_peak
// Brief    : Streaming |X|^2 with windowed per-frame peak detection.
//            Optional in_last checking enabled by FFT_MAG2_FRAME_CHECK_EN.
// Revision : 1.0
// ============================================================================
module fft_mag2_peak
    import fft_mag2_pkg::*;
#(
    parameter int BIT_WIDTH = c_def_bit_width,
    parameter int N_BINS    = c_def_n_bins,
    parameter int MIN_BIN   = c_def_min_bin,
    parameter int MAX_BIN   = c_def_max_bin
) (
    input  wire logic         clk,
    input  wire logic         reset,
    fft_mag2_peak_if.slave    bus
);
    localparam int c_idx_w = $clog2(N_BINS);
    localparam int c_mag_w = 2 * BIT_WIDTH;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_BINS - 1);
    localparam logic [c_idx_w-1:0] c_min_idx  = c_idx_w'(MIN_BIN);
    localparam logic [c_idx_w-1:0] c_max_idx  = c_idx_w'(MAX_BIN);
    localparam logic [c_mag_w-1:0] c_mag_rst  = c_mag_w'(c_trk_mag_rst);

    logic [c_idx_w-1:0] r_cnt;
    logic               w_cnt_last, w_eof, w_abort;

    assign w_cnt_last = (r_cnt == c_last_idx);

`ifdef FFT_MAG2_FRAME_CHECK_EN
    logic w_err, r_frame_err;

    // An early in_last closes the frame as an abort; a missing one is flagged but the counter still closes it.
    assign w_eof   = w_cnt_last | bus.in_last;
    assign w_abort = bus.in_last & ~w_cnt_last;
    assign w_err   = bus.in_valid & (bus.in_last ^ w_cnt_last);

    always_ff @(posedge clk) begin
        if (reset) r_frame_err <= 1'b0;
        else       r_frame_err <= w_err;
    end

    assign bus.frame_err = r_frame_err;
`else
    logic w_unused_last;

    assign w_eof         = w_cnt_last;
    assign w_abort       = 1'b0;
    assign w_unused_last = bus.in_last;
    assign bus.frame_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)             r_cnt <= '0;
        else if (bus.in_valid) r_cnt <= w_eof ? '0 : r_cnt + c_idx_w'(1);
    end

    logic               w_mag_valid, w_mag_eof, w_mag_abort;
    logic [c_mag_w-1:0] w_mag_data;
    logic [c_idx_w-1:0] w_mag_idx;

    fft_mag2_pipe #(
        .BIT_WIDTH (BIT_WIDTH),
        .IDX_W     (c_idx_w)
    ) u_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (bus.in_valid),
        .i_re    (bus.in_data[c_mag_w-1:BIT_WIDTH]),
        .i_im    (bus.in_data[BIT_WIDTH-1:0]),
        .i_idx   (r_cnt),
        .i_eof   (w_eof),
        .i_abort (w_abort),
        .o_valid (w_mag_valid),
        .o_mag   (w_mag_data),
        .o_idx   (w_mag_idx),
        .o_eof   (w_mag_eof),
        .o_abort (w_mag_abort)
    );

    assign bus.mag_valid = w_mag_valid;
    assign bus.mag_data  = w_mag_data;
    assign bus.mag_idx   = w_mag_idx;

    logic [c_idx_w-1:0] r_best_idx, r_peak_idx, w_fin_idx;
    logic [c_mag_w-1:0] r_best_mag, r_peak_mag, w_fin_mag;
    logic               r_peak_valid, w_in_win, w_upd;

    assign w_in_win  = (w_mag_idx >= c_min_idx) && (w_mag_idx <= c_max_idx);
    assign w_upd     = w_mag_valid && w_in_win && (w_mag_data > r_best_mag);
    assign w_fin_idx = w_upd ? w_mag_idx  : r_best_idx;
    assign w_fin_mag = w_upd ? w_mag_data : r_best_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_best_idx   <= c_min_idx;
            r_best_mag   <= c_mag_rst;
            r_peak_valid <= 1'b0;
            r_peak_idx   <= '0;
            r_peak_mag   <= '0;
        end else begin
            r_peak_valid <= 1'b0;
            if (w_mag_valid && w_mag_eof) begin
                if (!w_mag_abort) begin
                    r_peak_valid <= 1'b1;
                    r_peak_idx   <= w_fin_idx;
                    r_peak_mag   <= w_fin_mag;
                end
                r_best_idx <= c_min_idx;
                r_best_mag <= c_mag_rst;
            end else if (w_upd) begin
                r_best_idx <= w_mag_idx;
                r_best_mag <= w_mag_data;
            end
        end
    end

    assign bus.peak_valid = r_peak_valid;
    assign bus.peak_idx   = r_peak_idx;
    assign bus.peak_mag   = r_peak_mag;

endmodule : fft_mag2_peak
`default_nettype wire
